// File: rtl/seq_array_divider_if.sv
// Handshake/bus bundle for seq_array_divider.
// The master drives the operands and the result acceptance.
// The slave (the divider) drives readiness and the result.
interface seq_array_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz
    );
endinterface

// File: rtl/seq_array_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor.
// Optional macro SEQ_ARRAY_DIVIDER_DBZ_EN enables divide-by-zero early exit:
// a zero divisor finishes in one edge with dbz=1.
// Without the macro, dbz is tied 0 and a zero divisor runs the normal path.
module seq_array_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_array_divider_if.slave  bus
);
    localparam int unsigned QW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [QW-1:0]      quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
`ifdef SEQ_ARRAY_DIVIDER_DBZ_EN
    logic               dbz_q;
`endif

    // Trial subtraction of the divisor from the partial remainder with the next dividend bit.
    always_comb begin
        shifted = {rem, quo[QW-1]};
        trial   = shifted - {1'b0, dvs};
    end

    // Control FSM plus quotient/remainder shift datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
`ifdef SEQ_ARRAY_DIVIDER_DBZ_EN
            dbz_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        quo   <= bus.dividend;
                        dvs   <= bus.divisor;
                        rem   <= '0;
                        cnt   <= CW'(QW - 1);
                        state <= RUN;
`ifdef SEQ_ARRAY_DIVIDER_DBZ_EN
                        dbz_q <= 1'b0;
                        // Zero divisor: publish the saturated result immediately.
                        if (bus.divisor == '0) begin
                            quo   <= '1;
                            rem   <= bus.dividend[WIDTH-1:0];
                            dbz_q <= 1'b1;
                            state <= DONE;
                        end
`endif
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                    end
                    quo <= {quo[QW-2:0], ~trial[WIDTH]};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags are decoded straight from the state register.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quo;
    assign bus.remainder = rem;
`ifdef SEQ_ARRAY_DIVIDER_DBZ_EN
    assign bus.dbz       = dbz_q;
`else
    assign bus.dbz       = 1'b0;
`endif
endmodule
